rs_rx_core: RTL and testbench

RS_RX_CORE -- requirements
Module: rs_rx_core

---
 rtl/rs_rx_core.sv | 192 +++++++++++++++++++
 tb/tb_rs_rx_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_rx_core.sv
// rs_rx_core: 8N1 asynchronous serial receiver.
//
// Purpose
//   Synchronizes the RxD line and detects a start bit on a falling edge.
//   It confirms the start bit at mid-bit, then samples 8 data bits (LSB first)
//   and the stop bit at one-bit-period spacing. A good frame is presented on
//   RxData/RxReady. A stop bit sampled low gives a FrameErr pulse instead.
//
// Ports
//   F50Clk      in   1  50 MHz system clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   BitRateSel  in   4  bit-rate select (registered; latched per frame)
//   RxD         in   1  asynchronous serial line, idle high
//   RxAck       in   1  consumer acknowledge, clears RxReady
//   RxData      out  8  last correctly framed byte
//   RxReady     out  1  high while RxData holds an unacknowledged byte
//   FrameErr    out  1  one-cycle pulse on a low stop bit
//   OvrErr      out  1  one-cycle pulse when a good byte overwrites an unread one
module rs_rx_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       F50Clk,
   input  logic       reset_n,
   input  logic [3:0] BitRateSel,
   input  logic       RxD,
   input  logic       RxAck,
   output logic [7:0] RxData,
   output logic       RxReady,
   output logic       FrameErr,
   output logic       OvrErr
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             sel_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_rxd;
   logic                   prev_q;
   logic                   fall;
   logic [14:0]            per_sel;
   logic [14:0]            cnt_q, cnt_d;
   logic [14:0]            per_q, per_d;
   logic [14:0]            half_q, half_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             data_q, data_d;
   logic                   ready_q, ready_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   // Input conditioning: the synchronizer resets to the idle (high) level.
   // This means a reset can only be followed by a frame after a real 1->0 edge.
   always_ff @(posedge F50Clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
         sel_q  <= 4'h3;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
         prev_q <= s_rxd;
         sel_q  <= BitRateSel;
      end
   end

   assign s_rxd = sync_q[SYNC_STAGES-1];
   assign fall  = prev_q & ~s_rxd;

   // Bit period in clock cycles for the registered rate select
   always_comb begin
      case (sel_q)
         4'h1:    per_sel = 15'd20833;
         4'h2:    per_sel = 15'd10416;
         4'h3:    per_sel = 15'd5208;
         4'h4:    per_sel = 15'd2604;
         4'h5:    per_sel = 15'd1302;
         4'h6:    per_sel = 15'd868;
         4'h7:    per_sel = 15'd434;
         4'h8:    per_sel = 15'd217;
         4'h9:    per_sel = 15'd108;
         4'hA:    per_sel = 15'd54;
         4'hF:    per_sel = 15'd8;
         default: per_sel = 15'd5208;
      endcase
   end

   // Receive FSM. The counter restarts at every sample point and stops at its
   // target minus one. It therefore never exceeds P-1, and P and H are frozen
   // at start detection so a rate change cannot disturb a frame in flight.
   // A load takes priority over an acknowledge in the same cycle, so
   // RxReady stays set for the new byte.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      half_d  = half_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = ready_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (RxAck) begin
         ready_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_d   = 15'd0;
               per_d   = per_sel;
               half_d  = per_sel >> 1;
            end
         end
         START: begin
            if (cnt_q == half_q - 15'd1) begin
               cnt_d = 15'd0;
               bit_d = 3'd0;
               if (s_rxd) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q + 15'd1;
            end
         end
         DATA: begin
            if (cnt_q == per_q - 15'd1) begin
               cnt_d   = 15'd0;
               shift_d = {s_rxd, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 15'd1;
            end
         end
         STOP: begin
            if (cnt_q == per_q - 15'd1) begin
               cnt_d   = 15'd0;
               state_d = IDLE;
               if (s_rxd) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  ovr_d   = ready_q & ~RxAck;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 15'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge F50Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 15'd0;
         per_q   <= 15'd0;
         half_q  <= 15'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign RxData   = data_q;
   assign RxReady  = ready_q;
   assign FrameErr = ferr_q;
   assign OvrErr   = ovr_q;

endmodule

// File: tb/tb_rs_rx_core.sv
// tb_rs_rx_core: directed bench for rs_rx_core.
//
// Purpose
//   Drives serial frames at chosen bit periods and pushes each byte that
//   should be delivered onto a queue. A monitor pops the queue whenever
//   the receiver presents a new byte. Error pulses are counted per step.
//
// Ports
//   none (top-level bench)
module tb_rs_rx_core;

   localparam int SYNC = 2;
   localparam int PF   = 8;
   localparam int HF   = PF / 2;

   logic       F50Clk;
   logic       reset_n;
   logic [3:0] BitRateSel;
   logic       RxD;
   logic       RxAck;
   logic [7:0] RxData;
   logic       RxReady;
   logic       FrameErr;
   logic       OvrErr;

   int         vectors;
   int         miscompares;
   int         fe_cycles;
   int         ovr_cycles;
   logic [7:0] exp_q[$];
   logic [7:0] exp_byte;
   logic       prev_ready;
   logic [7:0] prev_data;

   rs_rx_core #(.SYNC_STAGES(SYNC)) dut (
      .F50Clk    (F50Clk),
      .reset_n   (reset_n),
      .BitRateSel(BitRateSel),
      .RxD       (RxD),
      .RxAck     (RxAck),
      .RxData    (RxData),
      .RxReady   (RxReady),
      .FrameErr  (FrameErr),
      .OvrErr    (OvrErr)
   );

   initial F50Clk = 1'b0;
   always #5 F50Clk = ~F50Clk;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: observed no completion, expected finish before limit");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Scoreboard monitor: a new byte is a rising RxReady or a data change while ready
   always @(negedge F50Clk) begin
      if (FrameErr) fe_cycles++;
      if (OvrErr) ovr_cycles++;
      if (RxReady && (!prev_ready || RxData !== prev_data)) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL unexpected_byte: observed %h, expected no delivery", RxData);
         end else begin
            exp_byte = exp_q.pop_front();
            assert (RxData === exp_byte) else begin
               miscompares++;
               $error("[TB] FAIL rx_byte: observed %h, expected %h", RxData, exp_byte);
            end
         end
      end
      prev_ready = RxReady;
      prev_data  = RxData;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge F50Clk);
   endtask

   // One frame, bit by bit, starting at cycle 0 (the start bit). ack_cycle and
   // sel_cycle pick the cycle on which RxAck pulses / BitRateSel changes (-1: never).
   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int p,
                             input int ack_cycle, input int sel_cycle,
                             input logic [3:0] new_sel, input logic idle_level);
      logic [9:0] bits;
      bits = {stop_bit, data, 1'b0};
      for (int c = 0; c < 10 * p; c++) begin
         @(negedge F50Clk);
         RxD   = bits[c / p];
         RxAck = (c == ack_cycle);
         if (c == sel_cycle) BitRateSel = new_sel;
      end
      @(negedge F50Clk);
      RxD   = idle_level;
      RxAck = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge F50Clk);
      RxAck = 1'b1;
      @(negedge F50Clk);
      RxAck = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      fe_cycles   = 0;
      ovr_cycles  = 0;
      prev_ready  = 1'b0;
      prev_data   = 8'h00;
      reset_n     = 1'b0;
      BitRateSel  = 4'hF;
      RxD         = 1'b1;
      RxAck       = 1'b0;

      // Reset state
      wait_cycles(3);
      check_val("reset_data", RxData, 8'h00);
      check_val("reset_ready", RxReady, 1'b0);
      check_val("reset_ferr", FrameErr, 1'b0);
      check_val("reset_ovr", OvrErr, 1'b0);
      reset_n = 1'b1;
      wait_cycles(4);

      // Framing error, then line held low: exactly one pulse, nothing delivered
      fe_cycles = 0;
      send_frame(8'hA3, 1'b0, PF, -1, -1, 4'hF, 1'b0);
      wait_cycles(40);
      RxD = 1'b1;
      wait_cycles(4);
      check_val("ferr_pulse_cycles", fe_cycles, 1);
      check_val("ferr_ready", RxReady, 1'b0);
      check_val("ferr_data", RxData, 8'h00);

      // Glitch reject, then a frame starting right after H+1+sync cycles
      fe_cycles = 0;
      @(negedge F50Clk);
      RxD = 1'b0;
      wait_cycles(2);
      RxD = 1'b1;
      wait_cycles(SYNC + HF + 1);
      check_val("glitch_ready", RxReady, 1'b0);
      check_val("glitch_ferr", fe_cycles, 0);

      // Good frame 0x55
      ovr_cycles = 0;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, PF, -1, -1, 4'hF, 1'b1);
      wait_cycles(4);
      check_val("good_queue_empty", exp_q.size(), 0);
      check_val("good_ready", RxReady, 1'b1);
      check_val("good_data", RxData, 8'h55);
      check_val("good_ferr", fe_cycles, 0);
      check_val("good_ovr", ovr_cycles, 0);

      // Acknowledge clears; acknowledge while empty is ignored
      pulse_ack();
      check_val("ack_clear", RxReady, 1'b0);
      pulse_ack();
      check_val("ack_idle_ready", RxReady, 1'b0);
      check_val("ack_idle_data", RxData, 8'h55);

      // Overrun: two back-to-back frames with no acknowledge
      ovr_cycles = 0;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, PF, -1, -1, 4'hF, 1'b1);
      exp_q.push_back(8'h34);
      send_frame(8'h34, 1'b1, PF, -1, -1, 4'hF, 1'b1);
      wait_cycles(4);
      check_val("ovr_queue_empty", exp_q.size(), 0);
      check_val("ovr_data", RxData, 8'h34);
      check_val("ovr_ready", RxReady, 1'b1);
      check_val("ovr_pulse_cycles", ovr_cycles, 1);

      // Same two frames, acknowledge on the cycle of the second load
      pulse_ack();
      ovr_cycles = 0;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, PF, -1, -1, 4'hF, 1'b1);
      exp_q.push_back(8'h34);
      send_frame(8'h34, 1'b1, PF, SYNC + HF + 9 * PF, -1, 4'hF, 1'b1);
      wait_cycles(4);
      check_val("ackload_queue_empty", exp_q.size(), 0);
      check_val("ackload_data", RxData, 8'h34);
      check_val("ackload_ready", RxReady, 1'b1);
      check_val("ackload_ovr", ovr_cycles, 0);

      // Rate change mid-frame: 0xC9 at P=434, select switched to f in DATA
      pulse_ack();
      BitRateSel = 4'h7;
      wait_cycles(4);
      fe_cycles  = 0;
      ovr_cycles = 0;
      exp_q.push_back(8'hC9);
      send_frame(8'hC9, 1'b1, 434, -1, 4 * 434, 4'hF, 1'b1);
      wait_cycles(4);
      check_val("rate_queue_empty", exp_q.size(), 0);
      check_val("rate_data", RxData, 8'hC9);
      pulse_ack();
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, PF, -1, -1, 4'hF, 1'b1);
      wait_cycles(4);
      check_val("rate_next_queue_empty", exp_q.size(), 0);
      check_val("rate_next_data", RxData, 8'h3C);
      check_val("rate_errs", fe_cycles + ovr_cycles, 0);

      // Reset during DATA: partial frame dropped, reset acts without a clock
      @(negedge F50Clk);
      RxD = 1'b0;
      wait_cycles(PF + 3 * PF);
      RxD = 1'b1;
      wait_cycles(PF);
      #1;
      reset_n = 1'b0;
      #1;
      check_val("async_reset_ready", RxReady, 1'b0);
      check_val("async_reset_data", RxData, 8'h00);
      wait_cycles(3);
      reset_n = 1'b1;
      wait_cycles(4);
      fe_cycles  = 0;
      ovr_cycles = 0;
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, PF, -1, -1, 4'hF, 1'b1);
      wait_cycles(4 * PF);
      check_val("rst_queue_empty", exp_q.size(), 0);
      check_val("rst_data", RxData, 8'h0F);
      check_val("rst_ready", RxReady, 1'b1);
      check_val("rst_errs", fe_cycles + ovr_cycles, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
